// File: rtl/p_step_driver_pkg.sv
// Shared definitions for the project-harness step driver: command and
// state encodings plus the bit layout of the packed harness words.
package p_step_pkg;

  localparam int IW_W = 18;
  localparam int OW_W = 24;

  localparam int IW_CLK     = 0;
  localparam int IW_RSTN    = 1;
  localparam int IW_UI_LSB  = 2;
  localparam int IW_UI_MSB  = 9;
  localparam int IW_UIO_LSB = 10;
  localparam int IW_UIO_MSB = 17;

  localparam int OW_UO_LSB      = 0;
  localparam int OW_UO_MSB      = 7;
  localparam int OW_UIO_OUT_LSB = 8;
  localparam int OW_UIO_OUT_MSB = 15;
  localparam int OW_UIO_OE_LSB  = 16;
  localparam int OW_UIO_OE_MSB  = 23;

  typedef enum logic [1:0] {
    OP_RESET  = 2'b00,
    OP_STEP   = 2'b01,
    OP_POKE   = 2'b10,
    OP_SAMPLE = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_HI,
    S_RST_LO,
    S_RST_REL,
    S_STP_HI,
    S_STP_LO,
    S_POKE,
    S_RESP
  } state_e;

  // Builds the packed harness input word from its individual fields.
  function automatic logic [IW_W-1:0] packIw(input logic [7:0] uio,
                                             input logic [7:0] ui,
                                             input logic       rstn,
                                             input logic       clk);
    logic [IW_W-1:0] w;
    w = '0;
    w[IW_CLK]                 = clk;
    w[IW_RSTN]                = rstn;
    w[IW_UI_MSB:IW_UI_LSB]    = ui;
    w[IW_UIO_MSB:IW_UIO_LSB]  = uio;
    return w;
  endfunction

endpackage

// File: rtl/p_step_driver_pulser.sv
// Pulse generator shared by RESET and STEP: loads a pulse count on start,
// alternates HI/LO phases, and flags the final LO phase so the caller can
// leave its pulse loop.
module p_step_pulser
  import p_step_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_count,
  output logic       o_hi,
  output logic       o_done
);

  logic [7:0] r_cnt;
  logic       r_hi;

  // Phase/count register. An idle pulser sits in LO with a zero count; a
  // start with a nonzero count opens the first HI phase on the next cycle,
  // and each LO phase either re-enters HI or, at count 1, finishes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_hi  <= 1'b0;
    end else if (i_start) begin
      r_cnt <= i_count;
      r_hi  <= (i_count != 8'd0);
    end else if (r_hi) begin
      r_hi <= 1'b0;
    end else if (r_cnt == 8'd1) begin
      r_cnt <= '0;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
      r_hi  <= 1'b1;
    end
  end

  assign o_hi   = r_hi;
  assign o_done = !r_hi && (r_cnt == 8'd1);

endmodule

// File: rtl/p_step_driver.sv
// Sequencer that steps one formal project harness: builds the packed
// harness input word, issues derived project-clock pulses, and returns one
// sampled output word per command.
module p_step_driver
  import p_step_pkg::*;
#(
  parameter int RST_CYCLES = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic [1:0]      i_cmd_op,
  input  logic [7:0]      i_cmd_count,
  input  logic [7:0]      i_cmd_ui,
  input  logic [7:0]      i_cmd_uio,
  output logic [IW_W-1:0] o_iw,
  input  logic [OW_W-1:0] i_ow,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [OW_W-1:0] o_rsp_data,
  output logic [15:0]     o_cyc_count,
  output logic            o_busy
);

  localparam logic [7:0] RST_CNT = 8'(RST_CYCLES);

  state_e          r_state;
  state_e          w_stateNext;
  op_e             w_op;
  logic            w_accept;
  logic            w_start;
  logic [7:0]      w_startCount;
  logic            w_pokeLoad;
  logic            w_rstLow;
  logic            w_rstRelease;
  logic            w_capture;
  logic            w_pulseHi;
  logic            w_pulseDone;
  logic [OW_W-1:0] w_owFields;
  logic [15:0]     w_cycNext;

  logic [7:0]      r_ui;
  logic [7:0]      r_uio;
  logic            r_rstn;
  logic            r_rspValid;
  logic [OW_W-1:0] r_rspData;
  logic [15:0]     r_cycCount;

  assign w_op        = op_e'(i_cmd_op);
  assign o_cmd_ready = (r_state == S_IDLE) && !r_rspValid;
  assign w_accept    = i_cmd_valid && o_cmd_ready;

  p_step_pulser u_pulser (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (w_start),
    .i_count (w_startCount),
    .o_hi    (w_pulseHi),
    .o_done  (w_pulseDone)
  );

  // Next-state and per-transition strobes. Every strobe marks an event on
  // the edge that ends this cycle (entering a state), which is what lets the
  // registered outputs line up with the state they belong to.
  always_comb begin
    w_stateNext  = r_state;
    w_start      = 1'b0;
    w_startCount = i_cmd_count;
    w_pokeLoad   = 1'b0;
    w_rstLow     = 1'b0;
    w_rstRelease = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (w_op)
            OP_RESET: begin
              w_stateNext  = S_RST_HI;
              w_start      = 1'b1;
              w_startCount = RST_CNT;
              w_rstLow     = 1'b1;
            end
            OP_STEP: begin
              if (i_cmd_count == 8'd0) begin
                w_stateNext = S_RESP;
                w_capture   = 1'b1;
              end else begin
                w_stateNext = S_STP_HI;
                w_start     = 1'b1;
              end
            end
            OP_POKE: begin
              w_stateNext = S_POKE;
              w_pokeLoad  = 1'b1;
            end
            default: begin
              w_stateNext = S_RESP;
              w_capture   = 1'b1;
            end
          endcase
        end
      end
      S_RST_HI: w_stateNext = S_RST_LO;
      S_RST_LO: begin
        if (w_pulseDone) begin
          w_stateNext  = S_RST_REL;
          w_rstRelease = 1'b1;
        end else begin
          w_stateNext = S_RST_HI;
        end
      end
      S_RST_REL: begin
        w_stateNext = S_RESP;
        w_capture   = 1'b1;
      end
      S_STP_HI: w_stateNext = S_STP_LO;
      S_STP_LO: begin
        if (w_pulseDone) begin
          w_stateNext = S_RESP;
          w_capture   = 1'b1;
        end else begin
          w_stateNext = S_STP_HI;
        end
      end
      S_POKE: begin
        w_stateNext = S_RESP;
        w_capture   = 1'b1;
      end
      S_RESP: begin
        if (i_rsp_ready) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // The pulse count advances on every entry into STP_HI and is cleared as
  // the reset sequence releases rst_n; it wraps freely at 16 bits.
  assign w_cycNext = w_rstRelease                ? 16'd0 :
                     (w_stateNext == S_STP_HI)   ? r_cycCount + 16'd1 :
                                                   r_cycCount;

  // The harness output is reassembled by named field so its layout is
  // defined only in the package.
  assign w_owFields = {i_ow[OW_UIO_OE_MSB:OW_UIO_OE_LSB],
                       i_ow[OW_UIO_OUT_MSB:OW_UIO_OUT_LSB],
                       i_ow[OW_UO_MSB:OW_UO_LSB]};

  // State, harness input fields, response and pulse counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_ui       <= '0;
      r_uio      <= '0;
      r_rstn     <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_cycCount <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_cycCount <= w_cycNext;
      if (w_pokeLoad) begin
        r_ui  <= i_cmd_ui;
        r_uio <= i_cmd_uio;
      end
      if (w_rstLow) begin
        r_rstn <= 1'b0;
      end else if (w_rstRelease) begin
        r_rstn <= 1'b1;
      end
      if (w_capture) begin
        r_rspValid <= 1'b1;
        r_rspData  <= w_owFields;
      end else if ((r_state == S_RESP) && i_rsp_ready) begin
        r_rspValid <= 1'b0;
      end
    end
  end

  assign o_iw        = packIw(r_uio, r_ui, r_rstn, w_pulseHi);
  assign o_rsp_valid = r_rspValid;
  assign o_rsp_data  = r_rspData;
  assign o_cyc_count = r_cycCount;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_p_step_driver.sv
// Directed bench for p_step_driver: a table of commands with hand-computed
// latency, response, harness input word and pulse count, plus hand-written
// sequences for backpressure, counter wrap and mid-command reset.
module tb_p_step_driver;

  localparam int R = 4;

  logic        clk;
  logic        rst;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOp;
  logic [7:0]  cmdCount;
  logic [7:0]  cmdUi;
  logic [7:0]  cmdUio;
  logic [17:0] iw;
  logic [23:0] ow;
  logic        rspValid;
  logic        rspReady;
  logic [23:0] rspData;
  logic [15:0] cycCount;
  logic        busy;

  int nCompared = 0;
  int nFailed   = 0;

  p_step_driver #(.RST_CYCLES(R)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd_valid (cmdValid),
    .o_cmd_ready (cmdReady),
    .i_cmd_op    (cmdOp),
    .i_cmd_count (cmdCount),
    .i_cmd_ui    (cmdUi),
    .i_cmd_uio   (cmdUio),
    .o_iw        (iw),
    .i_ow        (ow),
    .o_rsp_valid (rspValid),
    .i_rsp_ready (rspReady),
    .o_rsp_data  (rspData),
    .o_cyc_count (cycCount),
    .o_busy      (busy)
  );

  // Free-running system clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  count;
    logic [7:0]  ui;
    logic [7:0]  uio;
    logic [23:0] base;
    int          lat;
    int          pulses;
    logic [17:0] iwExp;
    logic [15:0] cycExp;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issues one command at a negedge, steps ow by one every cycle so the
  // sampled cycle is visible in rsp_data, checks the clk/rst_n waveform
  // cycle by cycle and the response, then consumes the response.
  task automatic applyStimulus(input vec_t v);
    int k;
    int clkBad;
    int rstnBad;
    bit gotRsp;
    logic expClk;
    logic expRstn;
    int w;
    w = 0;
    while (!cmdReady && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmdReady) begin
      checkOutput("cmdReadyWait", 32'(cmdReady), 32'd1);
      return;
    end
    cmdValid = 1'b1;
    cmdOp    = v.op;
    cmdCount = v.count;
    cmdUi    = v.ui;
    cmdUio   = v.uio;
    ow       = v.base;
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    k        = 1;
    ow       = v.base + 24'(k);
    clkBad   = 0;
    rstnBad  = 0;
    gotRsp   = 1'b0;
    while (k <= 600 && !gotRsp) begin
      @(negedge clk);
      expClk  = (k % 2 == 1) && (k <= 2 * v.pulses - 1);
      expRstn = (k > 2 * v.pulses);
      if (iw[0] !== expClk) clkBad++;
      if (v.op == 2'b00 && iw[1] !== expRstn) rstnBad++;
      if (rspValid === 1'b1) begin
        gotRsp = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        k++;
        ow = v.base + 24'(k);
      end
    end
    if (!gotRsp) begin
      checkOutput("rspTimeout", 32'(rspValid), 32'd1);
      return;
    end
    checkOutput("latency", 32'(k), 32'(v.lat));
    checkOutput("rspData", 32'(rspData), 32'(v.base + 24'(v.lat - 1)));
    checkOutput("iw", 32'(iw), 32'(v.iwExp));
    checkOutput("cycCount", 32'(cycCount), 32'(v.cycExp));
    checkOutput("clkPattern", 32'(clkBad), 32'd0);
    if (v.op == 2'b00) checkOutput("rstnPattern", 32'(rstnBad), 32'd0);
    rspReady = 1'b1;
    @(posedge clk);
    #1;
    rspReady = 1'b0;
    @(negedge clk);
    checkOutput("rspDrop", 32'(rspValid), 32'd0);
    checkOutput("readyBack", 32'(cmdReady), 32'd1);
  endtask

  initial begin
    int bad;
    rst      = 1'b1;
    cmdValid = 1'b0;
    cmdOp    = 2'b00;
    cmdCount = 8'd0;
    cmdUi    = 8'd0;
    cmdUio   = 8'd0;
    ow       = 24'd0;
    rspReady = 1'b0;

    //             op     cnt    ui     uio    base         lat  p    iw          cyc
    vecs[0]  = '{2'b00, 8'd0,   8'h00, 8'h00, 24'h100000, 10,  4,   18'h00002, 16'd0};
    vecs[1]  = '{2'b10, 8'd0,   8'hA5, 8'h3C, 24'h200000, 2,   0,   18'h0F296, 16'd0};
    vecs[2]  = '{2'b01, 8'd3,   8'h00, 8'h00, 24'h300000, 7,   3,   18'h0F296, 16'd3};
    vecs[3]  = '{2'b01, 8'd0,   8'h00, 8'h00, 24'h123456, 1,   0,   18'h0F296, 16'd3};
    vecs[4]  = '{2'b11, 8'd0,   8'h00, 8'h00, 24'h123456, 1,   0,   18'h0F296, 16'd3};
    vecs[5]  = '{2'b10, 8'd0,   8'hFF, 8'h00, 24'h400000, 2,   0,   18'h003FE, 16'd3};
    vecs[6]  = '{2'b01, 8'd1,   8'h00, 8'h00, 24'h500000, 3,   1,   18'h003FE, 16'd4};
    vecs[7]  = '{2'b01, 8'd255, 8'h00, 8'h00, 24'h600000, 511, 255, 18'h003FE, 16'h0103};
    vecs[8]  = '{2'b00, 8'd0,   8'h00, 8'h00, 24'h700000, 10,  4,   18'h003FE, 16'd0};
    vecs[9]  = '{2'b10, 8'd0,   8'h00, 8'hFF, 24'h800000, 2,   0,   18'h3FC02, 16'd0};
    vecs[10] = '{2'b11, 8'd0,   8'h00, 8'h00, 24'hABCDEF, 1,   0,   18'h3FC02, 16'd0};

    // Power-up reset values, then ready one cycle after release.
    repeat (3) @(negedge clk);
    checkOutput("resetIw", 32'(iw), 32'd0);
    checkOutput("resetRspValid", 32'(rspValid), 32'd0);
    checkOutput("resetRspData", 32'(rspData), 32'd0);
    checkOutput("resetCyc", 32'(cycCount), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterReset", 32'(cmdReady), 32'd1);

    for (int i = 0; i < 11; i++) begin
      $display("[TB] vector %0d op=%0d count=%0d", i, vecs[i].op, vecs[i].count);
      applyStimulus(vecs[i]);
    end

    // Backpressure: hold rsp_ready low for 5 cycles with a STEP offered.
    $display("[TB] backpressure");
    cmdValid = 1'b1;
    cmdOp    = 2'b11;
    cmdCount = 8'd0;
    ow       = 24'h0BEEF1;
    @(posedge clk);
    #1;
    cmdOp    = 2'b01;
    cmdCount = 8'd5;
    ow       = 24'h777777;
    @(negedge clk);
    checkOutput("bpRspValid", 32'(rspValid), 32'd1);
    checkOutput("bpRspData", 32'(rspData), 32'h0BEEF1);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rspData !== 24'h0BEEF1 || cmdReady !== 1'b0 || rspValid !== 1'b1 || iw[0] !== 1'b0)
        bad++;
    end
    checkOutput("bpHold", 32'(bad), 32'd0);
    cmdValid = 1'b0;
    rspReady = 1'b1;
    @(posedge clk);
    #1;
    rspReady = 1'b0;
    @(negedge clk);
    checkOutput("bpRelease", 32'(rspValid), 32'd0);
    checkOutput("bpReady", 32'(cmdReady), 32'd1);
    checkOutput("bpNoStep", 32'(cycCount), 32'd0);

    // Counter wrap: preload 0xFFFE through the counter's next-value net.
    $display("[TB] wrap");
    force dut.w_cycNext = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.w_cycNext;
    @(negedge clk);
    checkOutput("preload", 32'(cycCount), 32'h0000FFFE);
    applyStimulus('{2'b01, 8'd3, 8'h00, 8'h00, 24'h900000, 7, 3, 18'h3FC02, 16'h0001});

    // Reset during STEP 200, at the HI phase of pulse 50.
    $display("[TB] abort");
    cmdValid = 1'b1;
    cmdOp    = 2'b01;
    cmdCount = 8'd200;
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    repeat (98) @(posedge clk);
    @(negedge clk);
    checkOutput("abortPulseHi", 32'(iw[0]), 32'd1);
    checkOutput("abortCyc50", 32'(cycCount), 32'd51);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abortIw", 32'(iw), 32'd0);
    checkOutput("abortRspValid", 32'(rspValid), 32'd0);
    checkOutput("abortRspData", 32'(rspData), 32'd0);
    checkOutput("abortCyc", 32'(cycCount), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rspValid !== 1'b0 || cmdReady !== 1'b1 || busy !== 1'b0) bad++;
    end
    checkOutput("abortNoRsp", 32'(bad), 32'd0);
    applyStimulus('{2'b00, 8'd0, 8'h00, 8'h00, 24'hA00000, 10, 4, 18'h00002, 16'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
